// File: rtl/kernel_loader.sv
// Kernel byte buffer: fill up to NUM_KERNEL bytes, then stream them out
// over a valid/ready port one byte per accepted transfer.
//
// Ports:
//   clk, rst        - clock, async active-high reset
//   load, number    - write strobe and byte to store (FILL only)
//   start           - playback request pulse
//   out_ready       - downstream accept
//   out_valid       - out_data holds a kernel byte (PLAY only)
//   out_data        - current playback byte, 0 in FILL
//   count           - number of stored bytes
//   full            - count == NUM_KERNEL
//   busy            - high while in PLAY
module kernel_loader #(
  parameter int NUM_KERNEL = 8,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] number,
  input  logic             start,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       count,
  output logic             full,
  output logic             busy
);

  localparam int PW = (NUM_KERNEL > 1) ? $clog2(NUM_KERNEL) : 1;

  typedef enum logic {
    FILL = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [4:0]       count_q;
  logic [4:0]       count_n;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_n;
  logic             wr_en;
  logic [WIDTH-1:0] kernel [NUM_KERNEL];

  assign count = count_q;
  assign full  = (count_q == 5'(NUM_KERNEL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      count_q <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_n;
      count_q <= count_n;
      ptr     <= ptr_n;
    end
  end

  // Storage is deliberately not reset; contents survive playback and reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      kernel[count_q[PW-1:0]] <= number;
    end
  end

  always_comb begin
    state_n   = state;
    count_n   = count_q;
    ptr_n     = ptr;
    wr_en     = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    unique case (state)
      FILL: begin
        wr_en = load && !full;
        if (wr_en) begin
          count_n = count_q + 5'd1;
        end
        // A same-cycle load counts toward the start decision.
        if (start && (count_n != 5'd0)) begin
          state_n = PLAY;
          ptr_n   = '0;
        end
      end
      PLAY: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = kernel[ptr];
        if (out_ready) begin
          if (5'(ptr) == (count_q - 5'd1)) begin
            state_n = FILL;
            count_n = '0;
            ptr_n   = '0;
          end else begin
            ptr_n = ptr + PW'(1);
          end
        end
      end
      default: begin
        state_n = FILL;
      end
    endcase
  end

endmodule

// File: tb/tb_kernel_loader.sv
// Directed bench for kernel_loader: fill, playback, full, stall,
// same-cycle load/start and mid-playback reset.
module tb_kernel_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [7:0] number;
  logic       start;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       full;
  logic       busy;

  int checks = 0;
  int errors = 0;

  kernel_loader #(
    .NUM_KERNEL(8),
    .WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .number(number),
    .start(start),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .count(count),
    .full(full),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    load   = 1'b1;
    number = b;
    tick();
    load   = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    load      = 1'b0;
    number    = '0;
    start     = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Basic three-byte fill and playback
    load_byte(8'h11);
    check("cnt1", 32'(count), 32'd1);
    load_byte(8'h22);
    load_byte(8'h33);
    check("cnt3", 32'(count), 32'd3);
    check("fill_valid", 32'(out_valid), 32'd0);
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("p1_busy", 32'(busy), 32'd1);
    check("p1_valid", 32'(out_valid), 32'd1);
    check("p1_b0", 32'(out_data), 32'h11);
    tick();
    check("p1_b1", 32'(out_data), 32'h22);
    tick();
    check("p1_b2", 32'(out_data), 32'h33);
    tick();
    check("p1_end_busy", 32'(busy), 32'd0);
    check("p1_end_count", 32'(count), 32'd0);
    check("p1_end_valid", 32'(out_valid), 32'd0);
    check("p1_end_data", 32'(out_data), 32'd0);

    // Fill to full, overflow load ignored
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      load_byte(8'(i));
    end
    check("full8_flag", 32'(full), 32'd1);
    check("full8_count", 32'(count), 32'd8);
    load_byte(8'hFF);
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_full", 32'(full), 32'd1);
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("full_valid", 32'(out_valid), 32'd1);
      check("full_byte", 32'(out_data), 32'(i));
      tick();
    end
    check("full_end_busy", 32'(busy), 32'd0);
    check("full_end_count", 32'(count), 32'd0);

    // Start with nothing stored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_valid", 32'(out_valid), 32'd0);
    tick();
    check("empty_busy2", 32'(busy), 32'd0);

    // Same-cycle load and start
    out_ready = 1'b0;
    load_byte(8'h5A);
    load   = 1'b1;
    number = 8'hA5;
    start  = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b0;
    check("ls_busy", 32'(busy), 32'd1);
    check("ls_count", 32'(count), 32'd2);
    check("ls_b0", 32'(out_data), 32'h5A);
    out_ready = 1'b1;
    tick();
    check("ls_b1", 32'(out_data), 32'hA5);
    tick();
    check("ls_end_busy", 32'(busy), 32'd0);

    // Backpressure stall; load/start ignored in PLAY
    out_ready = 1'b0;
    load_byte(8'hC1);
    load_byte(8'hC2);
    load_byte(8'hC3);
    load_byte(8'hC4);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("st_b0", 32'(out_data), 32'hC1);
    tick();
    check("st_hold", 32'(out_data), 32'hC1);
    out_ready = 1'b1;
    tick();
    check("st_r1", 32'(out_data), 32'hC2);
    out_ready = 1'b0;
    load      = 1'b1;
    number    = 8'hEE;
    tick();
    load = 1'b0;
    check("st_s1", 32'(out_data), 32'hC2);
    check("st_s1_count", 32'(count), 32'd4);
    tick();
    check("st_s2", 32'(out_data), 32'hC2);
    check("st_s2_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    check("st_r2", 32'(out_data), 32'hC3);
    tick();
    check("st_r3", 32'(out_data), 32'hC4);
    tick();
    check("st_end_busy", 32'(busy), 32'd0);

    // Reset in the middle of playback
    load_byte(8'hD1);
    load_byte(8'hD2);
    load_byte(8'hD3);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mr_b1", 32'(out_data), 32'hD2);
    #2;
    rst = 1'b1;
    #1;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_data", 32'(out_data), 32'd0);
    check("mr_count", 32'(count), 32'd0);
    check("mr_full", 32'(full), 32'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    load_byte(8'h77);
    check("mr_load_count", 32'(count), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("mr_play", 32'(out_data), 32'h77);
    out_ready = 1'b1;
    tick();
    check("mr_end_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kernel_loader.md
KERNEL_LOADER -- requirements
Module: kernel_loader

Interface
REQ-001 Parameter NUM_KERNEL, default 8, SHALL set kernel entries; legal range 2..16.
REQ-002 Parameter WIDTH, default 8, SHALL set byte width of number and out_data.
REQ-003 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  SHALL be asynchronous, active-high reset.
REQ-005 load  input  1  SHALL be the write strobe qualifying number for one cycle.
REQ-006 number  input  WIDTH  SHALL be the kernel byte captured when load=1.
REQ-007 start  input  1  SHALL be a one-cycle pulse requesting playback.
REQ-008 out_ready  input  1  SHALL be the downstream accept signal.
REQ-009 out_valid  output  1  SHALL mean out_data holds a kernel byte.
REQ-010 out_data  output  WIDTH  SHALL be the current playback byte.
REQ-011 count  output  5  SHALL be the number of stored bytes.
REQ-012 full  output  1  SHALL be asserted when count==NUM_KERNEL.
REQ-013 busy  output  1  SHALL be asserted while in PLAY.

Function
REQ-014 FSM SHALL have two states: FILL and PLAY; busy=1 only in PLAY.
REQ-015 In FILL, load=1 with full=0 SHALL write number to kernel[count] and increment count the next cycle.
REQ-016 In FILL, load=1 with full=1 SHALL be ignored; no write, count unchanged.
REQ-017 In FILL, start=1 with count==0, after counting any same-cycle load, SHALL be ignored.
REQ-018 In FILL, start=1 with count>0 SHALL enter PLAY next cycle with ptr=0.
REQ-019 Simultaneous load and start in FILL SHALL store the byte first; playback SHALL include it.
REQ-020 In PLAY, out_valid SHALL be 1 and out_data SHALL equal kernel[ptr] combinationally.
REQ-021 out_valid and out_data SHALL hold stable until out_ready=1; a transfer occurs when out_valid and out_ready are both 1.
REQ-022 On a transfer with ptr<count-1, ptr SHALL increment by 1.
REQ-023 On a transfer with ptr==count-1, the FSM SHALL return to FILL and count SHALL clear to 0 on the same edge.
REQ-024 In PLAY, load and start SHALL be ignored; kernel contents SHALL not change.
REQ-025 In FILL, out_valid SHALL be 0 and out_data SHALL be 0.
REQ-026 Throughput SHALL be one byte per cycle while out_ready is held high; first out_valid SHALL occur one cycle after accepted start.
REQ-027 Kernel storage contents SHALL be retained after playback; only count and ptr clear.

Reset
REQ-028 rst=1 SHALL immediately force FILL, with count=0, ptr=0, out_valid=0, out_data=0, full=0, and busy=0.
REQ-029 rst asserted mid-PLAY SHALL abort playback without a further transfer; kernel storage need not be cleared.
REQ-030 After rst deasserts, the first load SHALL be accepted on the next rising edge.

Verification
REQ-031 Load 0x11,0x22,0x33, then start with out_ready=1 -> out_data 0x11,0x22,0x33 on 3 consecutive cycles, then busy=0 and count=0.
REQ-032 Load 8 bytes 0x00..0x07, then a 9th load of 0xFF -> full=1, count=8; playback yields 0x00..0x07 and no 0xFF.
REQ-033 Start with count=0 -> busy remains 0 and out_valid remains 0.
REQ-034 Same-cycle load 0xA5 and start with count=1 (0x5A) -> playback yields 0x5A then 0xA5.
REQ-035 In PLAY, toggle out_ready 1,0,0,1 -> ptr advances only on ready cycles; out_data remains stable during stall.
REQ-036 Assert rst during the 2nd byte of playback -> outputs go to reset values asynchronously; a subsequent load of 0x77 gives count=1.
